// File: rtl/data_mem_ctrl.sv
// Word-organised data memory with an RV32I load/store front end and a 3-state access FSM.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses.
module data_mem_ctrl #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 32
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              err,
  output logic [1:0]        dbg_state_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  // Handshake: req is sampled only in IDLE; ready is a one-cycle pulse in RESP, and
  // rdata/err are meaningful only while ready=1 (forced to 0 otherwise).
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              ready_q;
  logic              err_q;
  logic [31:0]       rdata_q;

  logic [31:0]       mem_q [DEPTH];

  logic              acc_we;
  logic [2:0]        acc_f3;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic              illegal;
  logic              rej;
  logic [1:0]        eff_lo;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       cur_word;
  logic [31:0]       lane;
  logic [31:0]       load_val;
  logic [31:0]       st_mask;
  logic [31:0]       st_data;
  logic [31:0]       new_word;
  logic              enter_resp;
  logic              mem_we;
  logic              unused_addr_hi;

  // In IDLE the access is taken straight from the inputs so a zero-wait access
  // can complete on its acceptance edge; afterwards the latched copy is used.
  always_comb begin
    acc_we    = we_q;
    acc_f3    = f3_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      acc_we    = we;
      acc_f3    = funct3;
      acc_addr  = addr;
      acc_wdata = wdata;
    end
  end

  always_comb begin
    illegal = 1'b0;
    if (acc_we) begin
      illegal = !(acc_f3 == 3'b000 || acc_f3 == 3'b001 || acc_f3 == 3'b010);
    end else begin
      illegal = !(acc_f3 == 3'b000 || acc_f3 == 3'b001 || acc_f3 == 3'b010 ||
                  acc_f3 == 3'b100 || acc_f3 == 3'b101);
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalign;
  always_comb begin
    misalign = 1'b0;
    if (acc_f3[1:0] == 2'b01) misalign = acc_addr[0];
    if (acc_f3[1:0] == 2'b10) misalign = (acc_addr[1:0] != 2'b00);
    rej    = illegal || misalign;
    eff_lo = acc_addr[1:0];
  end
`else
  // Without the trap, low address bits below the access size are simply dropped.
  always_comb begin
    rej    = illegal;
    eff_lo = acc_addr[1:0];
    if (acc_f3[1:0] == 2'b01) eff_lo = {acc_addr[1], 1'b0};
    if (acc_f3[1:0] == 2'b10) eff_lo = 2'b00;
  end
`endif

  assign idx            = acc_addr[IDX_W+1:2];
  assign unused_addr_hi = ^(acc_addr >> (IDX_W + 2));

  always_comb begin
    cur_word = mem_q[idx];
    lane     = cur_word >> {eff_lo, 3'b000};
    load_val = 32'd0;
    case (acc_f3)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
      3'b010:  load_val = lane;
      3'b100:  load_val = {24'd0, lane[7:0]};
      3'b101:  load_val = {16'd0, lane[15:0]};
      default: load_val = 32'd0;
    endcase
  end

  // Stores merge the shifted data into the current word under a lane mask.
  always_comb begin
    st_mask = 32'hFFFF_FFFF;
    case (acc_f3[1:0])
      2'b00:   st_mask = 32'h0000_00FF << {eff_lo, 3'b000};
      2'b01:   st_mask = 32'h0000_FFFF << {eff_lo, 3'b000};
      default: st_mask = 32'hFFFF_FFFF;
    endcase
    st_data  = acc_wdata << {eff_lo, 3'b000};
    new_word = (cur_word & ~st_mask) | (st_data & st_mask);
  end

  always_comb begin
    enter_resp = 1'b0;
    if (state_q == S_IDLE && req && WAIT_STATES == 0) enter_resp = 1'b1;
    if (state_q == S_WAIT && cnt_q == 4'd0)           enter_resp = 1'b1;
    mem_we = enter_resp && acc_we && !rej && RESET_N;
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[idx] <= new_word;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= 32'd0;
          if (req) begin
            we_q    <= we;
            f3_q    <= funct3;
            addr_q  <= addr;
            wdata_q <= wdata;
            if (WAIT_STATES == 0) begin
              state_q <= S_RESP;
              ready_q <= 1'b1;
              err_q   <= rej;
              rdata_q <= (!acc_we && !rej) ? load_val : 32'd0;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= WS_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_RESP;
            ready_q <= 1'b1;
            err_q   <= rej;
            rdata_q <= (!acc_we && !rej) ? load_val : 32'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= 32'd0;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= 32'd0;
        end
      endcase
    end
  end

  assign rdata       = rdata_q;
  assign ready       = ready_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule
